// File: rtl/tx_frame_sched.sv
// tx_frame_sched: round-robin grant of NCH 12-bit sample sources onto one hex-report UART,
// generating the baud enable and gating it only on whole-frame boundaries.
module tx_frame_sched #(
    parameter int NCH         = 4,
    parameter int DIV         = 434,
    parameter int CHAR_BITS   = 10,
    parameter int FRAME_CHARS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NCH-1:0]    req,
    input  logic [12*NCH-1:0] ch_data,
    output logic [NCH-1:0]    ack,
    output logic [11:0]       tx_data,
    output logic              tx_enx,
    output logic              busy,
    output logic [$clog2(NCH)-1:0] cur_ch,
    output logic              frame_done
);
    localparam int CW          = $clog2(NCH);
    localparam int FRAME_TICKS = CHAR_BITS * FRAME_CHARS;
    localparam int BW          = $clog2(DIV);
    localparam int TW          = $clog2(FRAME_TICKS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [CW-1:0]  rr_q, rr_d, ch_q, ch_d, sel;
    logic [11:0]    data_q, data_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic           busy_q, busy_d, done_q, done_d, grant, last_tick;
    logic [CW:0]    j;

    // Walk downward so the last hit is the nearest set req at or after rr_q.
    always_comb begin
        sel = rr_q;
        j   = '0;
        for (int i = NCH-1; i >= 0; i--) begin
            j = {1'b0, rr_q} + (CW+1)'(i);
            j = (j >= (CW+1)'(NCH)) ? j - (CW+1)'(NCH) : j;
            if (req[j[CW-1:0]]) sel = j[CW-1:0];
        end
    end

    assign grant     = (state_q == IDLE) && enable && |req;
    assign tx_enx    = (state_q == SEND) && (baud_q == BW'(DIV-1));
    assign last_tick = tx_enx && (tick_q == TW'(FRAME_TICKS-1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        tick_d  = tick_q;
        rr_d    = rr_q;
        ch_d    = ch_q;
        data_d  = data_q;
        busy_d  = busy_q;
        ack_d   = '0;
        done_d  = 1'b0;
        if (grant) begin
            state_d = SEND;
            baud_d  = '0;
            tick_d  = '0;
            ch_d    = sel;
            data_d  = ch_data[12*int'(sel) +: 12];
            rr_d    = (sel == CW'(NCH-1)) ? '0 : sel + 1'b1;
            ack_d   = NCH'(1) << sel;
            busy_d  = 1'b1;
        end else if (state_q == SEND) begin
            baud_d  = tx_enx ? '0 : baud_q + 1'b1;
            tick_d  = last_tick ? '0 : (tx_enx ? tick_q + 1'b1 : tick_q);
            state_d = last_tick ? IDLE : SEND;
            busy_d  = !last_tick;
            done_d  = last_tick;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            tick_q  <= '0;
            rr_q    <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            tick_q  <= tick_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign ack        = ack_q;
    assign tx_data    = data_q;
    assign busy       = busy_q;
    assign cur_ch     = ch_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_tx_frame_sched.sv
// tb_tx_frame_sched: table-driven frame checks plus hand sequences for enable drop,
// mid-frame reset and idle behaviour of the round-robin UART frame scheduler.
module tb_tx_frame_sched;
    localparam int NCH = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic [3:0]    req = '0;
    logic [47:0]   ch_data;
    logic [3:0]    ack;
    logic [11:0]   tx_data;
    logic          tx_enx, busy, frame_done;
    logic [1:0]    cur_ch;

    int  checks = 0;
    int  errors = 0;
    time last_tick_t = 0;

    typedef struct {
        logic [3:0]  rq;
        logic [3:0]  rq_after;
        int          ch;
        logic [11:0] data;
        bit          gap;
        bit          chg;
    } vec_t;

    vec_t tbl[12];

    tx_frame_sched #(.NCH(NCH), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .ch_data(ch_data),
        .ack(ack), .tx_data(tx_data), .tx_enx(tx_enx), .busy(busy),
        .cur_ch(cur_ch), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for the grant, then follows the frame to frame_done, checking cadence and hold.
    task automatic do_frame(input int ch, input logic [11:0] d, input logic [3:0] rq_after,
                            input bit gap, input bit chg, input bit drop);
        int w, cyc, ticks, last, bad_sp, bad_ack, bad_data, bad_gap;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (ack == 4'b0 && w < 20);
        chk("grant_ack", {28'b0, ack}, 32'b1 << ch);
        chk("grant_ch", {30'b0, cur_ch}, ch);
        chk("grant_data", {20'b0, tx_data}, {20'b0, d});
        chk("grant_busy_noenx", {30'b0, busy, tx_enx}, 32'b10);
        req = rq_after;
        cyc = 0; ticks = 0; last = 0; bad_sp = 0; bad_ack = 0; bad_data = 0; bad_gap = 0;
        while (!frame_done && cyc < 80*DIV + 20) begin
            @(negedge clk);
            cyc++;
            if (tx_enx) begin
                if (cyc - last != (ticks == 0 ? DIV-1 : DIV)) bad_sp++;
                if (gap && ticks == 0 && ($time - last_tick_t) > (DIV+1)*10) bad_gap++;
                last = cyc;
                last_tick_t = $time;
                ticks++;
                if (chg && ticks == 20) ch_data[12*ch +: 12] = 12'hFFF;
                if (drop && ticks == 40) enable = 1'b0;
            end
            if (ack != 4'b0) bad_ack++;
            if (tx_data != d) bad_data++;
        end
        chk("frame_done_seen", {31'b0, frame_done}, 1);
        chk("tick_count", ticks, 80);
        chk("tick_spacing", bad_sp, 0);
        chk("done_after_last", cyc - last, 1);
        chk("held_data", bad_data, 0);
        chk("single_ack", bad_ack, 0);
        chk("busy_at_done", {31'b0, busy}, 0);
        if (gap) chk("frame_gap", bad_gap, 0);
    endtask

    initial begin
        int n_enx, n_busy, n_ack, t;
        ch_data = {12'h3C7, 12'hA5C, 12'h123, 12'h111};
        tbl[0]  = '{4'hF, 4'hF, 0, 12'h111, 1'b0, 1'b0};
        tbl[1]  = '{4'hF, 4'hF, 1, 12'h123, 1'b1, 1'b1};
        tbl[2]  = '{4'hF, 4'hF, 2, 12'hA5C, 1'b1, 1'b0};
        tbl[3]  = '{4'hF, 4'hF, 3, 12'h3C7, 1'b1, 1'b0};
        tbl[4]  = '{4'hF, 4'hF, 0, 12'h111, 1'b1, 1'b0};
        tbl[5]  = '{4'hF, 4'hF, 1, 12'hFFF, 1'b1, 1'b0};
        tbl[6]  = '{4'hF, 4'hF, 2, 12'hA5C, 1'b1, 1'b0};
        tbl[7]  = '{4'hF, 4'hF, 3, 12'h3C7, 1'b1, 1'b0};
        tbl[8]  = '{4'hF, 4'h0, 0, 12'h111, 1'b1, 1'b0};
        tbl[9]  = '{4'h4, 4'h0, 2, 12'hA5C, 1'b0, 1'b0};
        tbl[10] = '{4'hA, 4'h0, 3, 12'h3C7, 1'b0, 1'b0};
        tbl[11] = '{4'hA, 4'h0, 1, 12'hFFF, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {12'b0, ack, tx_data, tx_enx, busy, cur_ch, frame_done}, 0);
        rst_n = 1'b1;
        n_enx = 0; n_busy = 0;
        repeat (1000) begin
            @(negedge clk);
            n_enx += int'(tx_enx);
            n_busy += int'(busy);
        end
        chk("idle_no_enx", n_enx, 0);
        chk("idle_no_busy", n_busy, 0);

        foreach (tbl[k]) begin
            req = tbl[k].rq;
            do_frame(tbl[k].ch, tbl[k].data, tbl[k].rq_after, tbl[k].gap, tbl[k].chg, 1'b0);
        end

        req = 4'hF;
        do_frame(2, 12'hA5C, 4'hF, 1'b0, 1'b0, 1'b1);
        n_enx = 0; n_busy = 0; n_ack = 0;
        repeat (100) begin
            @(negedge clk);
            n_enx += int'(tx_enx);
            n_busy += int'(busy);
            n_ack += int'(ack != 4'b0);
        end
        chk("disabled_no_enx", n_enx, 0);
        chk("disabled_no_ack", n_ack + n_busy, 0);
        enable = 1'b1;
        do_frame(3, 12'h3C7, 4'h0, 1'b0, 1'b0, 1'b0);

        req = 4'h1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ack == 4'b0 && t < 20);
        chk("rst_seq_grant", {28'b0, ack}, 32'h1);
        t = 0; n_enx = 0;
        while (n_enx < 37 && t < 400) begin
            @(negedge clk);
            t++;
            n_enx += int'(tx_enx);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midframe_reset", {12'b0, ack, tx_data, tx_enx, busy, cur_ch, frame_done}, 0);
        rst_n = 1'b1;
        do_frame(0, 12'h111, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
Round-robin scheduler that shares the single ASCII hex-report UART transmitter among NCH 12-bit sample sources (e.g. sigma-delta channels).
- Generates the transmitter's baud enable (tx_enx).
- Grants one requester per frame and holds its sample stable on tx_data for the whole frame.
- Gates the baud enable only on frame boundaries, so the transmitter's internal bit and character counters stay aligned.
- Frame: 8 characters × 10 bits = 80 enable ticks (space, 'x', 3 hex digits, CR, LF, space).

Parameters:
- NCH, 4, number of requesting channels (2..8).
- DIV, 434, clk cycles per baud tick (≥2); 434 = 115200 baud at 50 MHz.
- CHAR_BITS, 10, enable ticks per character (start + 8 data + stop).
- FRAME_CHARS, 8, characters per transmitter frame.
- Derived localparams: CW = $clog2(NCH); FRAME_TICKS = CHAR_BITS*FRAME_CHARS = 80.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; shared with the transmitter
- enable  in  1  global permission to start new frames
- req  in  NCH  per-channel "sample ready" level
- ch_data  in  12*NCH  channel i sample at bits [12*i+11 : 12*i]
- ack  out  NCH  one-cycle pulse: sample of channel i captured
- tx_data  out  12  sample to the transmitter, held for the whole frame
- tx_enx  out  1  baud-enable pulse to the transmitter
- busy  out  1  high while a frame is in progress
- cur_ch  out  CW  channel currently being (or last) sent
- frame_done  out  1  one-cycle pulse after the final tick of a frame

Behaviour:
- Reset: rst_n is synchronous, active-low; clock clk. When rst_n=0, on the next edge:
  - state=IDLE; all counters cleared; rr pointer=0.
  - tx_data=0, tx_enx=0, ack=0, busy=0, cur_ch=0, frame_done=0.
  - Reset mid-frame aborts immediately. This is legal because the transmitter resets on the same rst_n.
- States: IDLE, SEND.
- IDLE:
  - If enable=1 and |req: pick the first set req bit searching from rr pointer upward, modulo NCH.
  - On the next edge: tx_data<=ch_data[sel], cur_ch<=sel, ack[sel]=1 for that one cycle, rr<=(sel+1) mod NCH, busy<=1, baud_cnt<=0, tick_cnt<=0, state<=SEND.
  - Otherwise stay in IDLE with tx_enx=0.
- SEND:
  - baud_cnt counts 0..DIV-1 and wraps.
  - tx_enx=1 for exactly one cycle when baud_cnt==DIV-1; first pulse arrives DIV cycles after entering SEND.
  - tick_cnt increments on each tx_enx.
  - On the tx_enx with tick_cnt==FRAME_TICKS-1: next edge busy<=0, frame_done=1 for one cycle, state<=IDLE.
  - Every frame produces exactly 80 tx_enx pulses. The transmitter then ends at char 0 with the line idle high (stop bit).
- tx_data and cur_ch change only at grant. ch_data changes during SEND are ignored.
- enable deasserted during SEND: the current frame completes in full and no new grant is made. enable only gates grants.
- req deasserted during SEND: no effect. A channel whose req stays high is regranted on its next round-robin turn, and its data is re-sampled.
- Back-to-back frames: a grant can occur on the cycle frame_done is high. The minimum idle gap is 1 cycle plus DIV cycles before the first tick.
- Fairness: with all req high, the grant order is 0,1,…,NCH-1,0,… and no channel waits more than NCH-1 frames.
- Only one ack bit is high at a time; ack never coincides with tx_enx.

Test Plan:
1. Reset with NCH=4, DIV=4, req=0, enable=1 → all outputs 0; no tx_enx over 1000 cycles.
2. Single request: req=4'b0100, ch_data[2]=12'hA5C →
   - ack=4'b0100 for one cycle, tx_data=12'hA5C, cur_ch=2.
   - Exactly 80 tx_enx pulses spaced 4 cycles apart, then frame_done.
   - With the transmitter attached, the line decodes " xA5C\r\n ".
3. All req=4'b1111 held for 9 frames → ack order ch0,1,2,3,0,1,2,3,0; each frame is 80 ticks; gap between frames ≤ DIV+1 cycles.
4. enable dropped at tick 40 with req pending → current frame finishes at 80 ticks, frame_done pulses, no further ack or tx_enx until enable returns.
5. rst_n low for one cycle at tick 37 → tx_enx, busy, tx_data =0 next edge. After release with req=4'b0001, a clean 80-tick frame starts from ch0.
6. ch_data[1] changed from 12'h123 to 12'hFFF at tick 20 of a ch1 frame → tx_data remains 12'h123 until frame_done.
